// File: rtl/tx_iq_unpack_if.sv
// tx_iq_unpack_if: bundles the DMA-side word stream, the DUC-side sample
// stream and the TX control/status signals of tx_iq_unpack.
// slave  = the unpacker's view, master = the surrounding logic's view.
`timescale 1ns/1ps
interface tx_iq_unpack_if #(
  parameter int UFLOW_W = 16
);
  logic               tx_enable;
  logic               count_clr;
  logic [31:0]        s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [47:0]        m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               underflow;
  logic [UFLOW_W-1:0] underflow_count;

  modport slave (
    input  tx_enable, count_clr,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    output underflow, underflow_count
  );

  modport master (
    output tx_enable, count_clr,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input  underflow, underflow_count
  );
endinterface

// File: rtl/tx_iq_unpack.sv
// tx_iq_unpack: turns the 32-bit TX word stream (three words carry two packed
// 24-bit IQ pairs) into one 48-bit {Q,I} sample per transfer for the DUC.
// A three-phase FSM tracks word position; dropping tx_enable realigns it.
// Underflow events (DUC asks for a sample that is not there) are pulsed and
// counted with saturation.
// Optional build macro TX_UNDERFLOW_ZERO_EN: once primed, an emptied output is
// refilled with a zero sample so m_axis_tvalid stays high; each consumed zero
// is an underflow event.
`timescale 1ns/1ps
module tx_iq_unpack #(
  parameter int UFLOW_W = 16
) (
  input  logic           clk122,
  input  logic           reset,
  tx_iq_unpack_if.slave  bus
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_t;

  phase_t               r_phase;
  phase_t               w_phase_nxt;

  // Goes high the cycle after reset releases; keeps s_axis_tready low in reset.
  logic                 r_active;
  // W0 while waiting for W1, then W1[15:0] (I1[23:8]) while waiting for W2.
  logic [31:0]          r_hold_p0;
  // Output sample register presented to the DUC.
  logic [47:0]          r_tdata_p1;
  logic                 r_vld_p1;
  logic                 r_primed;
  logic                 r_underflow;
  logic [UFLOW_W-1:0]   r_count;
`ifdef TX_UNDERFLOW_ZERO_EN
  // Marks that the sample currently in the output register is a zero filler.
  logic                 r_zero_p1;
`endif

  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_consume;
  logic                 w_uf_evt;
  logic [47:0]          w_sample;

  function automatic logic [UFLOW_W-1:0] sat_inc(input logic [UFLOW_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A word is taken in P0 unconditionally, otherwise only if the output slot
  // is free or being emptied this cycle.
  assign w_s_ready = r_active & bus.tx_enable &
                     ((r_phase == P0) | !r_vld_p1 | bus.m_axis_tready);
  assign w_accept  = bus.s_axis_tvalid & w_s_ready;
  assign w_consume = r_vld_p1 & bus.m_axis_tready;
  assign w_load    = w_accept & (r_phase != P0);

  // Sample assembly: P1 completes {Q0,I0}, P2 completes {Q1,I1}.
  always_comb begin
    w_sample = '0;
    case (r_phase)
      P1: w_sample = {r_hold_p0[7:0], bus.s_axis_tdata[31:16], r_hold_p0[31:8]};
      P2: w_sample = {bus.s_axis_tdata[23:0], r_hold_p0[15:0], bus.s_axis_tdata[31:24]};
      default: w_sample = '0;
    endcase
  end

  // Underflow event definition depends on whether empties are zero-filled.
`ifdef TX_UNDERFLOW_ZERO_EN
  assign w_uf_evt = w_consume & r_zero_p1;
`else
  assign w_uf_evt = bus.tx_enable & r_primed & bus.m_axis_tready & !r_vld_p1;
`endif

  // Phase next-state: advance per accepted word, force P0 while disabled.
  always_comb begin
    w_phase_nxt = r_phase;
    if (!bus.tx_enable) begin
      w_phase_nxt = P0;
    end else if (w_accept) begin
      case (r_phase)
        P0:      w_phase_nxt = P1;
        P1:      w_phase_nxt = P2;
        default: w_phase_nxt = P0;
      endcase
    end
  end

  // Phase state register.
  always_ff @(posedge clk122) begin
    if (reset) r_phase <= P0;
    else       r_phase <= w_phase_nxt;
  end

  // Reset-release flag gating the input handshake.
  always_ff @(posedge clk122) begin
    if (reset) r_active <= 1'b0;
    else       r_active <= 1'b1;
  end

  // ---- stage p0: partial-word hold register ----
  // Hold the leftover bits of W0/W1; a disable discards any partial triplet.
  always_ff @(posedge clk122) begin
    if (!bus.tx_enable) begin
      r_hold_p0 <= '0;
    end else if (w_accept) begin
      case (r_phase)
        P0:      r_hold_p0 <= bus.s_axis_tdata;
        P1:      r_hold_p0 <= {r_hold_p0[31:16], bus.s_axis_tdata[15:0]};
        default: r_hold_p0 <= r_hold_p0;
      endcase
    end
  end

  // ---- stage p1: output sample register ----
  // Load on a completing word; on a bare consume either empty or zero-fill.
  always_ff @(posedge clk122) begin
    if (reset) begin
      r_tdata_p1 <= '0;
      r_vld_p1   <= 1'b0;
`ifdef TX_UNDERFLOW_ZERO_EN
      r_zero_p1  <= 1'b0;
`endif
    end else if (!bus.tx_enable) begin
      r_vld_p1   <= 1'b0;
`ifdef TX_UNDERFLOW_ZERO_EN
      r_zero_p1  <= 1'b0;
`endif
    end else if (w_load) begin
      r_tdata_p1 <= w_sample;
      r_vld_p1   <= 1'b1;
`ifdef TX_UNDERFLOW_ZERO_EN
      r_zero_p1  <= 1'b0;
`endif
    end else if (w_consume) begin
`ifdef TX_UNDERFLOW_ZERO_EN
      if (r_primed) begin
        r_tdata_p1 <= '0;
        r_zero_p1  <= 1'b1;
      end else begin
        r_vld_p1   <= 1'b0;
      end
`else
      r_vld_p1   <= 1'b0;
`endif
    end
  end

  // Primed after the first real sample of an enable period.
  always_ff @(posedge clk122) begin
    if (reset || !bus.tx_enable) r_primed <= 1'b0;
    else if (w_load)             r_primed <= 1'b1;
  end

  // Underflow pulse, one cycle per event.
  always_ff @(posedge clk122) begin
    if (reset) r_underflow <= 1'b0;
    else       r_underflow <= w_uf_evt;
  end

  // Saturating underflow counter; clear has priority over an increment.
  always_ff @(posedge clk122) begin
    if (reset)              r_count <= '0;
    else if (bus.count_clr) r_count <= '0;
    else if (w_uf_evt)      r_count <= sat_inc(r_count);
  end

  assign bus.s_axis_tready   = w_s_ready;
  assign bus.m_axis_tdata    = r_tdata_p1;
  assign bus.m_axis_tvalid   = r_vld_p1;
  assign bus.underflow       = r_underflow;
  assign bus.underflow_count = r_count;

endmodule

// File: tb/tb_tx_iq_unpack.sv
// tb_tx_iq_unpack: directed stimulus with a scoreboard queue of expected
// samples and an independent monitor that checks every DUC transfer.
`timescale 1ns/1ps
module tb_tx_iq_unpack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  tx_iq_unpack_if #(.UFLOW_W(16)) if_m ();
  tx_iq_unpack_if #(.UFLOW_W(4))  if_s ();

  tx_iq_unpack #(.UFLOW_W(16)) u_dut (.clk122(clk), .reset(rst), .bus(if_m));
  tx_iq_unpack #(.UFLOW_W(4))  u_sat (.clk122(clk), .reset(rst), .bus(if_s));

  // Narrow-counter instance sees exactly the same stimulus.
  assign if_s.tx_enable     = if_m.tx_enable;
  assign if_s.count_clr     = if_m.count_clr;
  assign if_s.s_axis_tdata  = if_m.s_axis_tdata;
  assign if_s.s_axis_tvalid = if_m.s_axis_tvalid;
  assign if_s.m_axis_tready = if_m.m_axis_tready;

  int total = 0;
  int bad   = 0;
  int got   = 0;
  int pulses = 0;
  int zeros  = 0;
  bit is_fill;
  logic [47:0] exp_q[$];
  logic [47:0] exp_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_m.underflow) pulses++;
      if (if_m.m_axis_tvalid && if_m.m_axis_tready) begin
        is_fill = 1'b0;
`ifdef TX_UNDERFLOW_ZERO_EN
        is_fill = (if_m.m_axis_tdata == 48'd0);
`endif
        if (is_fill) begin
          zeros++;
        end else if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_sample actual=%h required=none", if_m.m_axis_tdata);
        end else begin
          exp_s = exp_q.pop_front();
          total++; got++;
          if (if_m.m_axis_tdata !== exp_s) begin
            bad++;
            $display("FAIL sample actual=%h required=%h", if_m.m_axis_tdata, exp_s);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    if_m.s_axis_tdata  = w;
    if_m.s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!if_m.s_axis_tready && n < 200);
    if (!if_m.s_axis_tready) begin
      total++; bad++;
      $display("FAIL send_timeout actual=stalled required=accept word=%h", w);
    end
    @(posedge clk);
    #1;
    if_m.s_axis_tvalid = 1'b0;
  endtask

  // Packing is plain MSB-first concatenation of I0,Q0,I1,Q1.
  function automatic logic [95:0] pack(input logic [23:0] i0, q0, i1, q1);
    return {i0, q0, i1, q1};
  endfunction

  task automatic send_trip(input logic [95:0] t);
    send(t[95:64]);
    send(t[63:32]);
    send(t[31:0]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p0, z0, g0;
    logic [95:0] t;
    if_m.tx_enable     = 1'b0;
    if_m.count_clr     = 1'b0;
    if_m.s_axis_tdata  = '0;
    if_m.s_axis_tvalid = 1'b0;
    if_m.m_axis_tready = 1'b0;
    cyc(3);
    check("rst_tvalid", if_m.m_axis_tvalid, 0);
    check("rst_tdata",  if_m.m_axis_tdata, 0);
    check("rst_sready", if_m.s_axis_tready, 0);
    check("rst_uflow",  if_m.underflow, 0);
    check("rst_count",  if_m.underflow_count, 0);
    rst = 1'b0;
    cyc(2);

    // No underflow before priming even with the DUC requesting.
    if_m.tx_enable = 1'b1;
    if_m.m_axis_tready = 1'b1;
    cyc(5);
    check("unprimed_pulses", pulses, 0);

    // Unpack of the reference triplet.
    exp_q.push_back(48'h0000007FFFFF);
    exp_q.push_back(48'hABCDEF123456);
    send(32'h7FFFFF00);
    send(32'h00001234);
    check("lat_valid", if_m.m_axis_tvalid, 1);
    check("lat_data",  if_m.m_axis_tdata, 48'h0000007FFFFF);
    send(32'h56ABCDEF);
    check("lat_valid2", if_m.m_axis_tvalid, 1);
    check("lat_data2",  if_m.m_axis_tdata, 48'hABCDEF123456);
    cyc(4);
    check("unpack_drain", exp_q.size(), 0);

    // Backpressure: 30 words, DUC stalls 10 cycles mid-stream.
    g0 = got;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          t = pack(24'h100000 | 24'(k), 24'h200000 | 24'(k),
                   24'h300000 | 24'(k), 24'hC00000 | 24'(k));
          exp_q.push_back({t[71:48], t[95:72]});
          exp_q.push_back({t[23:0],  t[47:24]});
          send_trip(t);
        end
      end
      begin
        cyc(8);
        if_m.m_axis_tready = 1'b0;
        cyc(9);
        check("bp_stall_sready", if_m.s_axis_tready, 0);
        check("bp_stall_full",   if_m.m_axis_tvalid, 1);
        cyc(1);
        if_m.m_axis_tready = 1'b1;
      end
    join
    cyc(5);
    check("bp_count", got - g0, 20);
    check("bp_drain", exp_q.size(), 0);

    // Enable realign: partial triplet is dropped.
    if_m.m_axis_tready = 1'b0;
    send(32'h11111122);
    send(32'h22223333);
    cyc(1);
    if_m.tx_enable = 1'b0;
    cyc(1);
    check("dis_tvalid", if_m.m_axis_tvalid, 0);
    check("dis_sready", if_m.s_axis_tready, 0);
    if_m.tx_enable = 1'b1;
    if_m.m_axis_tready = 1'b1;
    p0 = pulses;
    cyc(4);
    check("realign_unprimed", pulses - p0, 0);
    exp_q.push_back(48'h654321123456);
    exp_q.push_back(48'hFEDCBA789ABC);
    send_trip(pack(24'h123456, 24'h654321, 24'h789ABC, 24'hFEDCBA));
    cyc(4);
    check("realign_drain", exp_q.size(), 0);

    // Underflow: feed 4 samples with single-cycle consumes, then starve.
    if_m.m_axis_tready = 1'b0;
    if_m.tx_enable = 1'b0;
    cyc(1);
    if_m.tx_enable = 1'b1;
    if_m.count_clr = 1'b1;
    cyc(1);
    if_m.count_clr = 1'b0;
    cyc(1);
    p0 = pulses;
    z0 = zeros;
    exp_q.push_back(48'hB00001A00001);
    exp_q.push_back(48'hB00002A00002);
    exp_q.push_back(48'hB00003A00003);
    exp_q.push_back(48'hB00004A00004);
    t = pack(24'hA00001, 24'hB00001, 24'hA00002, 24'hB00002);
    send(t[95:64]);
    send(t[63:32]);
    if_m.m_axis_tready = 1'b1;
    send(t[31:0]);
    if_m.m_axis_tready = 1'b0;
    t = pack(24'hA00003, 24'hB00003, 24'hA00004, 24'hB00004);
    send(t[95:64]);
    if_m.m_axis_tready = 1'b1;
    send(t[63:32]);
    if_m.m_axis_tready = 1'b0;
    if_m.m_axis_tready = 1'b1;
    send(t[31:0]);
    if_m.m_axis_tready = 1'b0;
    cyc(2);
    check("uf_none_while_fed", pulses - p0, 0);
    if_m.m_axis_tready = 1'b1;
    cyc(6);
    if_m.m_axis_tready = 1'b0;
    cyc(2);
    check("uf_pulses", pulses - p0, 5);
    check("uf_count",  if_m.underflow_count, 5);
    check("uf_drain",  exp_q.size(), 0);
`ifdef TX_UNDERFLOW_ZERO_EN
    check("uf_zeros", zeros - z0, 5);
    check("uf_zero_valid", if_m.m_axis_tvalid, 1);
`endif

    // Clear coinciding with an event wins.
    if_m.count_clr = 1'b1;
    if_m.m_axis_tready = 1'b1;
    cyc(1);
    if_m.count_clr = 1'b0;
    if_m.m_axis_tready = 1'b0;
    cyc(2);
    check("clr_wins", if_m.underflow_count, 0);
    check("clr_event_pulse", pulses - p0, 6);

    // Saturation: 20 events on a 16-bit and a 4-bit counter.
    if_m.count_clr = 1'b1;
    cyc(1);
    if_m.count_clr = 1'b0;
    if_m.m_axis_tready = 1'b1;
    cyc(20);
    if_m.m_axis_tready = 1'b0;
    cyc(2);
    check("sat_wide", if_m.underflow_count, 20);
    check("sat_narrow", if_s.underflow_count, 15);

    // Reset in the middle of a held sample.
    if_m.tx_enable = 1'b0;
    cyc(1);
    if_m.tx_enable = 1'b1;
    cyc(1);
    send(32'h0ABCDE01);
    send(32'h23450067);
    check("pre_rst_valid", if_m.m_axis_tvalid, 1);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_tvalid", if_m.m_axis_tvalid, 0);
    check("mid_rst_tdata",  if_m.m_axis_tdata, 0);
    check("mid_rst_sready", if_m.s_axis_tready, 0);
    check("mid_rst_uflow",  if_m.underflow, 0);
    check("mid_rst_count",  if_m.underflow_count, 0);
    check("mid_rst_count_narrow", if_s.underflow_count, 0);
    rst = 1'b0;
    cyc(3);
    check("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
